// File: rtl/pipe_ctrl_hazard_if.sv
// pipe_ctrl_hazard_if: ID-stage inputs, hazard controls and the staged control bundle of the hazard unit.
interface pipe_ctrl_hazard_if #(parameter int REG_AW = 5);
  logic              id_valid;
  logic [6:0]        id_opcode;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              ex_taken;
  logic              stall, ifid_flush, illegal_op;
  logic [1:0]        ex_alu_op;
  logic              ex_alu_src, ex_branch, ex_jump, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_mem_to_reg, wb_reg_write;
  logic [REG_AW-1:0] wb_rd;
  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_taken,
    input  stall, ifid_flush, illegal_op, ex_alu_op, ex_alu_src, ex_branch, ex_jump, ex_mem_read,
           ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_rd, mem_mem_read, mem_mem_write,
           mem_mem_to_reg, mem_reg_write, mem_rd, wb_mem_to_reg, wb_reg_write, wb_rd
  );
  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_taken,
    output stall, ifid_flush, illegal_op, ex_alu_op, ex_alu_src, ex_branch, ex_jump, ex_mem_read,
           ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_rd, mem_mem_read, mem_mem_write,
           mem_mem_to_reg, mem_reg_write, mem_rd, wb_mem_to_reg, wb_reg_write, wb_rd
  );
endinterface

// File: rtl/pipe_ctrl_hazard_unit.sv
// pipe_ctrl_hazard_unit: RV32I control decode, ID/EX-EX/MEM-MEM/WB control staging, load-use stall and branch squash.
module pipe_ctrl_hazard_unit #(
  parameter int REG_AW      = 5,
  parameter int FLUSH_SLOTS = 2,
  parameter int EN_JUMP     = 1
) (
  input logic clk,
  input logic reset_n,
  pipe_ctrl_hazard_if.slave bus
);
  typedef struct packed {
    logic       alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump;
    logic [1:0] alu_op;
  } ctrl_t;
  localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_IMM = 7'b0010011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam ctrl_t JUMP_C = 9'b1_0_1_0_0_0_1_00;
  ctrl_t             dec, id_c, ex_q;
  logic [REG_AW-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
  logic [3:0]        mem_q;
  logic [1:0]        wb_q;
  logic [2:0]        sq_cnt;
  logic              use1, use2, unsupported, taken_q, squash, hazard, live;
  always_comb begin
    dec  = '0;
    use1 = 1'b0;
    use2 = 1'b0;
    case (bus.id_opcode)
      OP_R:    begin dec = 9'b0_0_1_0_0_0_0_10; use1 = 1'b1; use2 = 1'b1; end
      OP_LD:   begin dec = 9'b1_1_1_1_0_0_0_00; use1 = 1'b1; end
      OP_ST:   begin dec = 9'b1_0_0_0_1_0_0_00; use1 = 1'b1; use2 = 1'b1; end
      OP_BR:   begin dec = 9'b0_0_0_0_0_1_0_01; use1 = 1'b1; use2 = 1'b1; end
      OP_IMM:  begin dec = 9'b1_0_1_0_0_0_0_11; use1 = 1'b1; end
      OP_JAL:  dec = EN_JUMP != 0 ? JUMP_C : '0;
      OP_JALR: begin dec = EN_JUMP != 0 ? JUMP_C : '0; use1 = EN_JUMP != 0; end
      default: dec = '0;
    endcase
  end
  // every supported opcode sets at least one control bit, so an all-zero decode means unsupported
  assign unsupported = ~|dec;
  always_comb begin
    id_c           = dec;
    id_c.reg_write = dec.reg_write & (bus.id_rd != '0);
  end
  assign taken_q = bus.ex_taken & (ex_q.branch | ex_q.jump);
  assign squash  = taken_q | (sq_cnt != 3'd0);
  assign hazard  = bus.id_valid & ex_q.mem_read & (ex_rd_q != '0) &
                   ((use1 & (ex_rd_q == bus.id_rs1)) | (use2 & (ex_rd_q == bus.id_rs2)));
  assign live    = bus.id_valid & ~squash & ~hazard;
  assign bus.stall      = hazard & ~squash;
  assign bus.ifid_flush = taken_q;
  assign bus.illegal_op = bus.id_valid & ~squash & unsupported;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sq_cnt   <= 3'd0;
      ex_q     <= '0;
      ex_rd_q  <= '0;
      mem_q    <= '0;
      mem_rd_q <= '0;
      wb_q     <= '0;
      wb_rd_q  <= '0;
    end else begin
      sq_cnt   <= taken_q ? 3'(FLUSH_SLOTS - 1) : (sq_cnt != 3'd0 ? sq_cnt - 3'd1 : 3'd0);
      ex_q     <= live & ~unsupported ? id_c : '0;
      ex_rd_q  <= live & ~unsupported ? bus.id_rd : '0;
      mem_q    <= {ex_q.mem_read, ex_q.mem_write, ex_q.mem_to_reg, ex_q.reg_write};
      mem_rd_q <= ex_rd_q;
      wb_q     <= mem_q[1:0];
      wb_rd_q  <= mem_rd_q;
    end
  end
  assign {bus.ex_alu_src, bus.ex_mem_to_reg, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
          bus.ex_branch, bus.ex_jump, bus.ex_alu_op} = ex_q;
  assign bus.ex_rd = ex_rd_q;
  assign {bus.mem_mem_read, bus.mem_mem_write, bus.mem_mem_to_reg, bus.mem_reg_write} = mem_q;
  assign bus.mem_rd = mem_rd_q;
  assign {bus.wb_mem_to_reg, bus.wb_reg_write} = wb_q;
  assign bus.wb_rd = wb_rd_q;
endmodule
